pipeline_run_controller: RTL and testbench
==========================================

Name: pipeline_run_controller

Overview:
Run/step/breakpoint sequencer for the 5-stage MIPS pipeline. It drives the pipeline's shared clkEnable to run, single-step or freeze all stages under host debug commands. It detects the program-end (halt) opcode at IF and drains in-flight instructions through WB before declaring completion. It sits between the debug host interface and the Pipeline top level, and also keeps a cycle counter.

Parameters:
PC_WIDTH, 10, width of the IF-stage PC and breakpoint address
HALT_OPCODE, 6'b111111, instr[31:26] value marking end of program
DRAIN_CYCLES, 4, enabled cycles after halt detection needed to retire older instructions
CNT_WIDTH, 32, cycle counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  00 NOP, 01 RUN, 10 STEP, 11 HALT
bp_enable  in  1  breakpoint armed
bp_pc  in  PC_WIDTH  breakpoint address
pc_if  in  PC_WIDTH  PC of the instruction currently in IF (PC_IFID)
instr_if  in  32  instruction currently in IF
clkEnable  out  1  pipeline-wide stage enable
state  out  3  current FSM state encoding
halted  out  1  state == HALTED
done  out  1  program finished (state == DONE)
bp_hit  out  1  last stop was caused by the breakpoint
cycle_count  out  CNT_WIDTH  number of enabled pipeline cycles

Behaviour:
- States: HALTED=0, RUN=1, STEP=2, DRAIN=3, DONE=4.
- Command accepted when cmd_valid && cmd_ready.
- cmd_ready = 1 in HALTED, RUN and DONE; 0 in STEP and DRAIN.
- Reset (reset=0, asynchronous):
  - state=HALTED, clkEnable=0, done=0, bp_hit=0, cycle_count=0.
  - drain counter=0, resume guard=0.
  - Takes effect immediately, including mid-RUN or mid-DRAIN.
- bp_match = bp_enable && (pc_if == bp_pc) && !guard.
- clkEnable is combinational from registered state and inputs:
  - 1 in STEP and DRAIN.
  - 1 in RUN unless bp_match; the breakpointed instruction is therefore held in IF, unexecuted.
  - 0 in HALTED and DONE.
- HALTED:
  - Accepted RUN -> RUN, guard=1, bp_hit=0.
  - Accepted STEP -> STEP, bp_hit=0.
  - NOP and HALT are consumed with no effect.
- RUN, priority order, evaluated each cycle:
  - (1) bp_match -> HALTED, bp_hit=1.
  - (2) instr_if[31:26]==HALT_OPCODE -> DRAIN, drain counter=DRAIN_CYCLES.
  - (3) accepted HALT -> HALTED.
  - (4) otherwise stay in RUN.
  - guard clears after the first RUN cycle, so resuming from a breakpoint advances past bp_pc.
  - RUN/STEP/NOP commands accepted in RUN are ignored.
- STEP:
  - Exactly one enabled cycle.
  - If instr_if holds the halt opcode in that cycle -> DRAIN; otherwise -> HALTED.
  - Breakpoint is not checked in STEP.
- DRAIN:
  - Counter decrements each cycle; the cycle in which it equals 1 transitions to DONE.
  - Gives exactly DRAIN_CYCLES enabled cycles, uninterruptible.
- DONE:
  - Terminal; done=1, clkEnable=0.
  - Commands are accepted and ignored; only reset exits DONE.
- cycle_count:
  - Increments on every rising edge where clkEnable=1.
  - Saturates at all-ones with no wrap.
  - Cleared only by reset.
- All outputs except clkEnable and cmd_ready are registered or decoded from registered state only.

Test Plan:
- Reset release, RUN, halt opcode at pc_if=5 (PC increments by 1 per cycle from 0):
  - Required: 6 RUN enabled cycles, then 4 DRAIN cycles, then done=1, clkEnable=0, cycle_count=10.
- bp_enable=1, bp_pc=3, RUN:
  - Required: clkEnable drops in the same cycle pc_if==3; next state HALTED, bp_hit=1, cycle_count=3.
  - Then RUN again: clkEnable=1 immediately and pc_if reaches 4; bp_hit=0.
- From HALTED, three accepted STEPs:
  - Required: each yields exactly one clkEnable=1 cycle; cmd_ready=0 during STEP; cycle_count=3; halted=1 after each.
- HALT command during RUN at cycle 7:
  - Required: state HALTED after that edge; clkEnable=0 from then on; cycle_count=8.
- reset pulled low during DRAIN (counter=2):
  - Required: clkEnable=0, state=HALTED and cycle_count=0 without waiting for a clock edge.
  - After release, RUN restarts normally.
- Coincident events with CNT_WIDTH=4:
  - bp_pc equal to the halt instruction's PC -> HALTED with bp_hit=1, not DRAIN.
  - 20 enabled cycles -> cycle_count saturates at 15.

Source files
------------

// File: rtl/pipeline_run_controller.sv
// ---------------------------------------------------------------------------
// pipeline_run_controller
//
// Run / single-step / breakpoint sequencer for the 5-stage MIPS pipeline.
// It drives the pipeline-wide clkEnable so that all stages run, step once or
// freeze under host debug commands. When the halt opcode reaches IF, the
// older in-flight instructions drain through WB before completion is flagged.
// A saturating counter records how many enabled pipeline cycles have elapsed.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   cmd_valid    host command valid
//   cmd_ready    controller can accept a command (HALTED, RUN, DONE)
//   cmd_op       00 NOP, 01 RUN, 10 STEP, 11 HALT
//   bp_enable    breakpoint armed
//   bp_pc        breakpoint address
//   pc_if        PC of the instruction currently in IF
//   instr_if     instruction currently in IF
//   clkEnable    pipeline-wide stage enable (combinational)
//   state        current FSM state encoding
//   halted       state == HALTED
//   done         program finished (state == DONE)
//   bp_hit       last stop was caused by the breakpoint
//   cycle_count  number of enabled pipeline cycles, saturating
// ---------------------------------------------------------------------------
module pipeline_run_controller #(
  parameter int unsigned PC_WIDTH     = 10,
  parameter logic [5:0]  HALT_OPCODE  = 6'b111111,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic                 bp_enable,
  input  logic [PC_WIDTH-1:0]  bp_pc,
  input  logic [PC_WIDTH-1:0]  pc_if,
  input  logic [31:0]          instr_if,
  output logic                 clkEnable,
  output logic [2:0]           state,
  output logic                 halted,
  output logic                 done,
  output logic                 bp_hit,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  typedef enum logic [2:0] {
    ST_HALTED = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_RUN  = 2'b01,
    OP_STEP = 2'b10,
    OP_HALT = 2'b11
  } op_e;

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);

  state_e               state_q, state_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic                 guard_q, guard_d;
  logic                 bp_hit_q, bp_hit_d;
  logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;

  logic cmd_acc;
  logic is_halt_op;
  logic bp_match;
  logic clk_en;

  assign cmd_ready  = (state_q == ST_HALTED) || (state_q == ST_RUN) ||
                      (state_q == ST_DONE);
  assign cmd_acc    = cmd_valid && cmd_ready;
  assign is_halt_op = (instr_if[31:26] == HALT_OPCODE);
  // The guard masks the breakpoint for the first cycle after a resume, so a
  // RUN issued while parked on bp_pc lets that instruction leave IF.
  assign bp_match   = bp_enable && (pc_if == bp_pc) && !guard_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    guard_d  = guard_q;
    bp_hit_d = bp_hit_q;
    clk_en   = 1'b0;

    unique case (state_q)
      ST_HALTED: begin
        if (cmd_acc && (op_e'(cmd_op) == OP_RUN)) begin
          state_d  = ST_RUN;
          guard_d  = 1'b1;
          bp_hit_d = 1'b0;
        end else if (cmd_acc && (op_e'(cmd_op) == OP_STEP)) begin
          state_d  = ST_STEP;
          bp_hit_d = 1'b0;
        end
      end

      ST_RUN: begin
        // Breakpoint freezes IF in the same cycle, leaving bp_pc unexecuted.
        clk_en  = !bp_match;
        guard_d = 1'b0;
        if (bp_match) begin
          state_d  = ST_HALTED;
          bp_hit_d = 1'b1;
        end else if (is_halt_op) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_INIT;
        end else if (cmd_acc && (op_e'(cmd_op) == OP_HALT)) begin
          state_d = ST_HALTED;
        end
      end

      ST_STEP: begin
        clk_en = 1'b1;
        if (is_halt_op) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          state_d = ST_HALTED;
        end
      end

      ST_DRAIN: begin
        clk_en  = 1'b1;
        drain_d = drain_q - DW'(1);
        if (drain_q == DW'(1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Terminal: commands are consumed and ignored until reset.
      end

      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  always_comb begin
    cycle_count_d = cycle_count_q;
    if (clk_en && (cycle_count_q != {CNT_WIDTH{1'b1}})) begin
      cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_HALTED;
      drain_q       <= '0;
      guard_q       <= 1'b0;
      bp_hit_q      <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      guard_q       <= guard_d;
      bp_hit_q      <= bp_hit_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign clkEnable   = clk_en;
  assign state       = state_q;
  assign halted      = (state_q == ST_HALTED);
  assign done        = (state_q == ST_DONE);
  assign bp_hit      = bp_hit_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_run_controller
//
// Directed bench for pipeline_run_controller. A tiny pipeline model advances
// pc_if by one on every enabled edge and presents the halt opcode in IF when
// pc_if reaches a chosen address. The DUT uses a 4-bit cycle counter so the
// saturation boundary is reachable quickly. Outputs are sampled at negedge.
// ---------------------------------------------------------------------------
module tb_pipeline_run_controller;

  localparam int unsigned PW = 10;
  localparam int unsigned CW = 4;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [2:0] S_HALTED = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic          bp_enable;
  logic [PW-1:0] bp_pc;
  logic [PW-1:0] pc_if;
  logic [31:0]   instr_if;
  logic          clkEnable;
  logic [2:0]    state;
  logic          halted;
  logic          done;
  logic          bp_hit;
  logic [CW-1:0] cycle_count;

  logic          halt_en;
  logic [PW-1:0] halt_pc;

  int total = 0;
  int bad   = 0;

  pipeline_run_controller #(
    .PC_WIDTH    (PW),
    .HALT_OPCODE (6'b111111),
    .DRAIN_CYCLES(4),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .bp_enable  (bp_enable),
    .bp_pc      (bp_pc),
    .pc_if      (pc_if),
    .instr_if   (instr_if),
    .clkEnable  (clkEnable),
    .state      (state),
    .halted     (halted),
    .done       (done),
    .bp_hit     (bp_hit),
    .cycle_count(cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pipeline model: IF advances only on enabled edges.
  always @(posedge clk or negedge reset) begin
    if (!reset) pc_if <= '0;
    else if (clkEnable) pc_if <= pc_if + PW'(1);
  end

  always_comb begin
    instr_if = 32'h0000_0020;
    if (halt_en && (pc_if == halt_pc)) instr_if = {6'b111111, 26'h0};
  end

  task automatic send_cmd(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP;
    bp_enable = 1'b0; bp_pc = '0; halt_en = 1'b0; halt_pc = '0;
    #3;
    total++; if (state !== S_HALTED) begin $display("FAIL reset_state got=%0d want=%0d", state, S_HALTED); bad++; end
    total++; if (clkEnable !== 1'b0) begin $display("FAIL reset_clken got=%b want=0", clkEnable); bad++; end
    total++; if (done !== 1'b0 || halted !== 1'b1) begin $display("FAIL reset_flags got done=%b halted=%b want 0/1", done, halted); bad++; end
    total++; if (bp_hit !== 1'b0) begin $display("FAIL reset_bphit got=%b want=0", bp_hit); bad++; end
    total++; if (cycle_count !== 4'd0) begin $display("FAIL reset_count got=%0d want=0", cycle_count); bad++; end
    total++; if (cmd_ready !== 1'b1) begin $display("FAIL reset_ready got=%b want=1", cmd_ready); bad++; end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_run_to_halt();
    int run_en = 0;
    int drain_en = 0;
    do_reset();
    halt_en = 1'b1; halt_pc = PW'(5);
    send_cmd(OP_RUN);
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      if (state == S_RUN   && clkEnable) run_en++;
      if (state == S_DRAIN && clkEnable) drain_en++;
      @(negedge clk);
    end
    total++; if (done !== 1'b1) begin $display("FAIL halt_done got=%b want=1 (timeout)", done); bad++; end
    total++; if (run_en != 6) begin $display("FAIL halt_run_cycles got=%0d want=6", run_en); bad++; end
    total++; if (drain_en != 4) begin $display("FAIL halt_drain_cycles got=%0d want=4", drain_en); bad++; end
    total++; if (clkEnable !== 1'b0) begin $display("FAIL halt_done_clken got=%b want=0", clkEnable); bad++; end
    total++; if (cycle_count !== 4'd10) begin $display("FAIL halt_count got=%0d want=10", cycle_count); bad++; end
    total++; if (cmd_ready !== 1'b1) begin $display("FAIL halt_done_ready got=%b want=1", cmd_ready); bad++; end
    send_cmd(OP_RUN);
    total++; if (state !== S_DONE || clkEnable !== 1'b0) begin $display("FAIL done_sticky got state=%0d en=%b want 4/0", state, clkEnable); bad++; end
    total++; if (cycle_count !== 4'd10) begin $display("FAIL done_count_hold got=%0d want=10", cycle_count); bad++; end
    halt_en = 1'b0;
  endtask

  task automatic test_breakpoint();
    do_reset();
    bp_enable = 1'b1; bp_pc = PW'(3);
    send_cmd(OP_RUN);
    for (int i = 0; i < 20; i++) begin
      if (pc_if == PW'(3)) break;
      @(negedge clk);
    end
    total++; if (pc_if !== PW'(3)) begin $display("FAIL bp_reach got pc=%0d want=3 (timeout)", pc_if); bad++; end
    total++; if (clkEnable !== 1'b0 || state !== S_RUN) begin $display("FAIL bp_same_cycle got en=%b state=%0d want 0/1", clkEnable, state); bad++; end
    @(negedge clk);
    total++; if (halted !== 1'b1 || bp_hit !== 1'b1) begin $display("FAIL bp_stop got halted=%b bp_hit=%b want 1/1", halted, bp_hit); bad++; end
    total++; if (cycle_count !== 4'd3 || pc_if !== PW'(3)) begin $display("FAIL bp_count got cnt=%0d pc=%0d want 3/3", cycle_count, pc_if); bad++; end
    send_cmd(OP_RUN);
    total++; if (clkEnable !== 1'b1 || bp_hit !== 1'b0) begin $display("FAIL bp_resume got en=%b bp_hit=%b want 1/0", clkEnable, bp_hit); bad++; end
    @(negedge clk);
    total++; if (pc_if !== PW'(4) || state !== S_RUN) begin $display("FAIL bp_past got pc=%0d state=%0d want 4/1", pc_if, state); bad++; end
    send_cmd(OP_HALT);
    bp_enable = 1'b0;
  endtask

  task automatic test_step();
    do_reset();
    // Breakpoint armed on the first stepped PC must not block the step.
    bp_enable = 1'b1; bp_pc = PW'(0);
    for (int k = 0; k < 3; k++) begin
      send_cmd(OP_STEP);
      total++; if (state !== S_STEP || cmd_ready !== 1'b0 || clkEnable !== 1'b1) begin
        $display("FAIL step_%0d_active got state=%0d ready=%b en=%b want 2/0/1", k, state, cmd_ready, clkEnable); bad++; end
      @(negedge clk);
      total++; if (halted !== 1'b1 || clkEnable !== 1'b0) begin
        $display("FAIL step_%0d_after got halted=%b en=%b want 1/0", k, halted, clkEnable); bad++; end
    end
    total++; if (cycle_count !== 4'd3 || pc_if !== PW'(3)) begin $display("FAIL step_count got cnt=%0d pc=%0d want 3/3", cycle_count, pc_if); bad++; end
    total++; if (bp_hit !== 1'b0) begin $display("FAIL step_bphit got=%b want=0", bp_hit); bad++; end
    bp_enable = 1'b0;
  endtask

  task automatic test_halt_cmd();
    do_reset();
    send_cmd(OP_RUN);
    repeat (7) @(negedge clk);
    send_cmd(OP_HALT);
    total++; if (state !== S_HALTED || clkEnable !== 1'b0) begin $display("FAIL hcmd_stop got state=%0d en=%b want 0/0", state, clkEnable); bad++; end
    total++; if (cycle_count !== 4'd8) begin $display("FAIL hcmd_count got=%0d want=8", cycle_count); bad++; end
    repeat (3) @(negedge clk);
    total++; if (clkEnable !== 1'b0 || cycle_count !== 4'd8) begin $display("FAIL hcmd_frozen got en=%b cnt=%0d want 0/8", clkEnable, cycle_count); bad++; end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    halt_en = 1'b1; halt_pc = PW'(2);
    send_cmd(OP_RUN);
    for (int i = 0; i < 20; i++) begin
      if (state == S_DRAIN) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    total++; if (state !== S_DRAIN || clkEnable !== 1'b1) begin $display("FAIL rd_pre got state=%0d en=%b want 3/1", state, clkEnable); bad++; end
    #2 reset = 1'b0;
    #1;
    total++; if (clkEnable !== 1'b0 || state !== S_HALTED || cycle_count !== 4'd0) begin
      $display("FAIL rd_async got en=%b state=%0d cnt=%0d want 0/0/0", clkEnable, state, cycle_count); bad++; end
    @(negedge clk);
    reset = 1'b1;
    halt_en = 1'b0;
    send_cmd(OP_RUN);
    repeat (3) @(negedge clk);
    total++; if (state !== S_RUN || cycle_count !== 4'd3 || pc_if !== PW'(3)) begin
      $display("FAIL rd_restart got state=%0d cnt=%0d pc=%0d want 1/3/3", state, cycle_count, pc_if); bad++; end
    send_cmd(OP_HALT);
  endtask

  task automatic test_coincident();
    do_reset();
    halt_en = 1'b1; halt_pc = PW'(4);
    bp_enable = 1'b1; bp_pc = PW'(4);
    send_cmd(OP_RUN);
    for (int i = 0; i < 20; i++) begin
      if (pc_if == PW'(4)) break;
      @(negedge clk);
    end
    total++; if (clkEnable !== 1'b0) begin $display("FAIL co_clken got=%b want=0", clkEnable); bad++; end
    @(negedge clk);
    total++; if (state !== S_HALTED || bp_hit !== 1'b1) begin $display("FAIL co_bp_wins got state=%0d bp_hit=%b want 0/1", state, bp_hit); bad++; end
    total++; if (cycle_count !== 4'd4) begin $display("FAIL co_count got=%0d want=4", cycle_count); bad++; end
    bp_enable = 1'b0; halt_en = 1'b0;
    send_cmd(OP_RUN);
    repeat (11) @(negedge clk);
    total++; if (cycle_count !== 4'd15) begin $display("FAIL sat_reach got=%0d want=15", cycle_count); bad++; end
    repeat (9) @(negedge clk);
    total++; if (cycle_count !== 4'd15 || pc_if !== PW'(24)) begin $display("FAIL sat_hold got cnt=%0d pc=%0d want 15/24", cycle_count, pc_if); bad++; end
    send_cmd(OP_HALT);
  endtask

  initial begin
    test_reset();
    test_run_to_halt();
    test_breakpoint();
    test_step();
    test_halt_cmd();
    test_reset_in_drain();
    test_coincident();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
